// File: rtl/usb_ep_bridge.sv
// usb_ep_bridge: multi-endpoint buffering bridge between the USB device
// controller packet interface and user logic. Channel k (IN and OUT FIFO
// pair) serves endpoint k+1. OUT packets are committed on a good CRC and
// rolled back otherwise.
// Optional feature: define USB_EP_BRIDGE_DROPCNT_EN to build per-channel
// 8-bit saturating counters of rolled-back OUT packets (out_drop_cnt_o);
// without it out_drop_cnt_o is tied to zero.
module usb_ep_bridge #(
    parameter int NUM_EP  = 2,
    parameter int DEPTH   = 1024,
    parameter int MAX_PKT = 512
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic [3:0]            endpt_i,
    input  logic                  txact_i,
    input  logic                  txpop_i,
    output logic [7:0]            txdat_o,
    output logic                  txval_o,
    output logic [11:0]           txdat_len_o,
    output logic                  txcork_o,
    input  logic [7:0]            rxdat_i,
    input  logic                  rxval_i,
    input  logic                  rxact_i,
    input  logic                  rxpktval_i,
    output logic                  rxrdy_o,
    input  logic [8*NUM_EP-1:0]   in_data_i,
    input  logic [NUM_EP-1:0]     in_valid_i,
    output logic [NUM_EP-1:0]     in_ready_o,
    output logic [8*NUM_EP-1:0]   out_data_o,
    output logic [NUM_EP-1:0]     out_valid_o,
    input  logic [NUM_EP-1:0]     out_ready_i,
    output logic [8*NUM_EP-1:0]   out_drop_cnt_o
);
    localparam int AW = $clog2(DEPTH);
    typedef logic [AW:0] ptr_t;
    localparam ptr_t DEPTH_L  = ptr_t'(DEPTH);
    localparam ptr_t MAXPKT_L = ptr_t'(MAX_PKT);

    typedef enum logic [1:0] {IDLE = 2'd0, TX = 2'd1, RX = 2'd2} state_t;

    // Full when the wrap bits differ and the address bits match.
    function automatic logic ptr_full(input ptr_t wr, input ptr_t rd);
        return (wr[AW] != rd[AW]) && (wr[AW-1:0] == rd[AW-1:0]);
    endfunction

    state_t state_r, state_nx_s;
    logic   txact_r, rxact_r;
    logic   bad_r, ok_r;
    logic [11:0] len_r;

    logic [7:0] in_mem_r  [NUM_EP][DEPTH];
    logic [7:0] out_mem_r [NUM_EP][DEPTH];
    ptr_t in_wr_r  [NUM_EP];
    ptr_t in_rd_r  [NUM_EP];
    ptr_t out_sh_r [NUM_EP];
    ptr_t out_cm_r [NUM_EP];
    ptr_t out_rd_r [NUM_EP];
    ptr_t out_sh_nx_s [NUM_EP];

    logic [NUM_EP-1:0] sel_hit_s, in_push_s, in_pop_s, in_nempty_s;
    logic [NUM_EP-1:0] out_wr_s, out_pop_s, out_ovf_s;
    logic       sel_any_s, sel_nempty_s;
    logic [7:0] sel_head_s;
    ptr_t       sel_lvl_s, sel_free_s;
    logic       rx_live_s, commit_s, fall_s, rollback_s;

    // Bytes are accepted only inside an RX transaction; a concurrent IN wins.
    assign rx_live_s  = (state_r == RX) && rxact_i && !txact_i;
    assign commit_s   = rxpktval_i && (state_r == RX) && !bad_r && sel_any_s;
    assign fall_s     = (state_r == RX) && !rxact_i;
    assign rollback_s = fall_s && !ok_r && !commit_s;

    // Transaction FSM state and activity-edge history.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_r <= IDLE;
            txact_r <= 1'b0;
            rxact_r <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            txact_r <= txact_i;
            rxact_r <= rxact_i;
        end
    end

    // Next-state: IN start has priority over OUT start.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (txact_i && !txact_r)      state_nx_s = TX;
                else if (rxact_i && !rxact_r) state_nx_s = RX;
                else                          state_nx_s = IDLE;
            end
            TX: begin
                if (!txact_i) state_nx_s = IDLE;
                else          state_nx_s = TX;
            end
            RX: begin
                if (!rxact_i) state_nx_s = IDLE;
                else          state_nx_s = RX;
            end
            default: state_nx_s = IDLE;
        endcase
    end

    // Per-channel flags and strobes plus the view of the addressed channel.
    always_comb begin
        sel_any_s    = 1'b0;
        sel_nempty_s = 1'b0;
        sel_head_s   = 8'd0;
        sel_lvl_s    = '0;
        sel_free_s   = '0;
        in_ready_o   = '0;
        out_valid_o  = '0;
        out_data_o   = '0;
        for (int k = 0; k < NUM_EP; k++) begin
            sel_hit_s[k]   = (endpt_i == 4'(k + 1));
            in_nempty_s[k] = (in_wr_r[k] != in_rd_r[k]);
            in_ready_o[k]  = !ptr_full(in_wr_r[k], in_rd_r[k]);
            in_push_s[k]   = in_valid_i[k] && in_ready_o[k];
            in_pop_s[k]    = txpop_i && (state_r == TX) && sel_hit_s[k] && in_nempty_s[k];
            out_ovf_s[k]   = ptr_full(out_sh_r[k], out_rd_r[k]);
            out_wr_s[k]    = rx_live_s && rxval_i && sel_hit_s[k] && !out_ovf_s[k];
            out_sh_nx_s[k] = out_wr_s[k] ? out_sh_r[k] + ptr_t'(1) : out_sh_r[k];
            out_valid_o[k] = (out_cm_r[k] != out_rd_r[k]);
            out_pop_s[k]   = out_valid_o[k] && out_ready_i[k];
            out_data_o[8*k +: 8] = out_valid_o[k] ? out_mem_r[k][out_rd_r[k][AW-1:0]] : 8'd0;
            sel_any_s    = sel_any_s | sel_hit_s[k];
            sel_nempty_s = sel_hit_s[k] ? in_nempty_s[k] : sel_nempty_s;
            sel_head_s   = sel_hit_s[k] ? in_mem_r[k][in_rd_r[k][AW-1:0]] : sel_head_s;
            sel_lvl_s    = sel_hit_s[k] ? (in_wr_r[k] - in_rd_r[k]) : sel_lvl_s;
            sel_free_s   = sel_hit_s[k] ? (DEPTH_L - (out_sh_r[k] - out_rd_r[k])) : sel_free_s;
        end
    end

    assign txdat_o     = sel_nempty_s ? sel_head_s : 8'd0;
    assign txval_o     = (state_r == TX) && sel_nempty_s;
    assign txcork_o    = !sel_nempty_s;
    assign rxrdy_o     = sel_any_s && (sel_free_s >= MAXPKT_L);
    assign txdat_len_o = len_r;

    // FIFO pointers: shadow write advances per byte, committed moves on commit.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int k = 0; k < NUM_EP; k++) begin
                in_wr_r[k]  <= '0;
                in_rd_r[k]  <= '0;
                out_sh_r[k] <= '0;
                out_cm_r[k] <= '0;
                out_rd_r[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_EP; k++) begin
                if (in_push_s[k]) in_wr_r[k] <= in_wr_r[k] + ptr_t'(1);
                if (in_pop_s[k])  in_rd_r[k] <= in_rd_r[k] + ptr_t'(1);
                if (out_pop_s[k]) out_rd_r[k] <= out_rd_r[k] + ptr_t'(1);
                if (rollback_s && sel_hit_s[k]) out_sh_r[k] <= out_cm_r[k];
                else                            out_sh_r[k] <= out_sh_nx_s[k];
                if (commit_s && sel_hit_s[k])   out_cm_r[k] <= out_sh_nx_s[k];
            end
        end
    end

    // FIFO storage; contents need no reset because pointers define validity.
    always_ff @(posedge clk_i) begin
        for (int k = 0; k < NUM_EP; k++) begin
            if (in_push_s[k]) in_mem_r[k][in_wr_r[k][AW-1:0]] <= in_data_i[8*k +: 8];
            if (out_wr_s[k])  out_mem_r[k][out_sh_r[k][AW-1:0]] <= rxdat_i;
        end
    end

    // Per-packet status: cleared at RX start, set on overflow or on commit.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            bad_r <= 1'b0;
            ok_r  <= 1'b0;
        end else if ((state_r == IDLE) && (state_nx_s == RX)) begin
            bad_r <= 1'b0;
            ok_r  <= 1'b0;
        end else begin
            if (rx_live_s && rxval_i && |(sel_hit_s & out_ovf_s)) bad_r <= 1'b1;
            if (commit_s) ok_r <= 1'b1;
        end
    end

    // Next IN packet length: follows the selected level while idle, held in TX/RX.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i)               len_r <= 12'd0;
        else if (state_r == IDLE)  len_r <= (sel_lvl_s > MAXPKT_L) ? 12'(MAX_PKT) : 12'(sel_lvl_s);
        else                       len_r <= len_r;
    end

`ifdef USB_EP_BRIDGE_DROPCNT_EN
    logic [7:0] drop_r [NUM_EP];

    // Saturating count of rolled-back OUT packets per channel.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int k = 0; k < NUM_EP; k++) drop_r[k] <= 8'd0;
        end else begin
            for (int k = 0; k < NUM_EP; k++) begin
                if (rollback_s && sel_hit_s[k] && (drop_r[k] != 8'hFF))
                    drop_r[k] <= drop_r[k] + 8'd1;
            end
        end
    end

    // Pack counters onto the output bus.
    always_comb begin
        out_drop_cnt_o = '0;
        for (int k = 0; k < NUM_EP; k++) out_drop_cnt_o[8*k +: 8] = drop_r[k];
    end
`else
    assign out_drop_cnt_o = '0;
`endif

endmodule

// File: tb/tb_usb_ep_bridge.sv
// Self-checking bench for usb_ep_bridge: directed sequence with random payload
// bytes, checked against queue-based reference FIFOs.
module tb_usb_ep_bridge;
    localparam int NUM_EP  = 2;
    localparam int DEPTH   = 1024;
    localparam int MAX_PKT = 512;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic [3:0]  endpt_i;
    logic        txact_i, txpop_i;
    logic [7:0]  txdat_o;
    logic        txval_o;
    logic [11:0] txdat_len_o;
    logic        txcork_o;
    logic [7:0]  rxdat_i;
    logic        rxval_i, rxact_i, rxpktval_i;
    logic        rxrdy_o;
    logic [8*NUM_EP-1:0] in_data_i;
    logic [NUM_EP-1:0]   in_valid_i;
    logic [NUM_EP-1:0]   in_ready_o;
    logic [8*NUM_EP-1:0] out_data_o;
    logic [NUM_EP-1:0]   out_valid_o;
    logic [NUM_EP-1:0]   out_ready_i;
    logic [8*NUM_EP-1:0] out_drop_cnt_o;

    always #5 clk_i = ~clk_i;

    usb_ep_bridge #(.NUM_EP(NUM_EP), .DEPTH(DEPTH), .MAX_PKT(MAX_PKT)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .endpt_i(endpt_i),
        .txact_i(txact_i), .txpop_i(txpop_i), .txdat_o(txdat_o), .txval_o(txval_o),
        .txdat_len_o(txdat_len_o), .txcork_o(txcork_o),
        .rxdat_i(rxdat_i), .rxval_i(rxval_i), .rxact_i(rxact_i), .rxpktval_i(rxpktval_i),
        .rxrdy_o(rxrdy_o),
        .in_data_i(in_data_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .out_data_o(out_data_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_drop_cnt_o(out_drop_cnt_o)
    );

    int checks = 0;
    int errors = 0;
    logic [7:0] q0[$];    // reference IN FIFO ch0
    logic [7:0] q1[$];    // reference IN FIFO ch1
    logic [7:0] oq[$];    // reference committed OUT FIFO ch1
    logic [7:0] pend[$];  // OUT packet bytes not yet committed
    logic [7:0] b;
    logic [7:0] exp_drop;
    int n;

`ifdef USB_EP_BRIDGE_DROPCNT_EN
    localparam logic [7:0] DROP_STEP = 8'd1;
`else
    localparam logic [7:0] DROP_STEP = 8'd0;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [11:0] exp_len(input int lvl);
        return (lvl > MAX_PKT) ? 12'(MAX_PKT) : 12'(lvl);
    endfunction

    initial begin
        rstn_i = 1'b0; endpt_i = 4'd0; txact_i = 1'b0; txpop_i = 1'b0;
        rxdat_i = 8'd0; rxval_i = 1'b0; rxact_i = 1'b0; rxpktval_i = 1'b0;
        in_data_i = '0; in_valid_i = '0; out_ready_i = '0;
        exp_drop = 8'd0;
        repeat (3) tick();

        // Reset state
        check("rst_txcork", txcork_o, 1);
        check("rst_txval", txval_o, 0);
        check("rst_len", txdat_len_o, 0);
        check("rst_in_ready", in_ready_o, 2'b11);
        check("rst_out_valid", out_valid_o, 0);
        check("rst_out_data", out_data_o, 0);
        check("rst_rxrdy", rxrdy_o, 0);
        check("rst_drop", out_drop_cnt_o, 0);
        rstn_i = 1'b1;
        tick();

        // Endpoint selection
        endpt_i = 4'd2; #1;
        check("rxrdy_ep2", rxrdy_o, 1);
        endpt_i = 4'd3; #1;
        check("rxrdy_ep3_unmapped", rxrdy_o, 0);
        check("cork_ep3_unmapped", txcork_o, 1);

        // IN short packet on ch0
        endpt_i = 4'd1;
        for (int i = 0; i < 5; i++) begin
            b = 8'($urandom);
            in_data_i[7:0] = b; in_valid_i = 2'b01; q0.push_back(b);
            tick();
        end
        in_valid_i = '0;
        tick(); tick();
        check("short_len", txdat_len_o, exp_len(q0.size()));
        check("short_cork", txcork_o, 0);
        check("short_txval_idle", txval_o, 0);
        txact_i = 1'b1; tick(); tick();
        for (int i = 0; i < 5; i++) begin
            check("short_txval", txval_o, 1);
            check("short_dat", txdat_o, q0[0]);
            txpop_i = 1'b1; tick();
            b = q0.pop_front();
        end
        txpop_i = 1'b0;
        check("short_cork_end", txcork_o, 1);
        check("short_txval_end", txval_o, 0);
        txpop_i = 1'b1; tick(); txpop_i = 1'b0;
        check("pop_empty_ignored", txcork_o, 1);
        txact_i = 1'b0; tick(); tick();
        check("short_len_end", txdat_len_o, 0);

        // IN split packet on ch1
        for (int i = 0; i < 700; i++) begin
            b = 8'($urandom);
            in_data_i[15:8] = b; in_valid_i = 2'b10; q1.push_back(b);
            tick();
        end
        in_valid_i = '0;
        endpt_i = 4'd2; tick(); tick();
        check("split_len_first", txdat_len_o, exp_len(q1.size()));
        txact_i = 1'b1; tick(); tick();
        for (int i = 0; i < MAX_PKT; i++) begin
            if (i == 300) check("split_len_frozen", txdat_len_o, 12'd512);
            check("split_dat", txdat_o, q1[0]);
            txpop_i = 1'b1; tick();
            b = q1.pop_front();
        end
        txpop_i = 1'b0; txact_i = 1'b0; tick(); tick();
        check("split_len_second", txdat_len_o, exp_len(q1.size()));
        txact_i = 1'b1; tick(); tick();
        n = q1.size();
        for (int i = 0; i < n; i++) begin
            check("split_dat2", txdat_o, q1[0]);
            txpop_i = 1'b1; tick();
            b = q1.pop_front();
        end
        txpop_i = 1'b0; txact_i = 1'b0; tick();
        check("split_cork_end", txcork_o, 1);

        // OUT good packet on endpoint 2
        endpt_i = 4'd2; rxact_i = 1'b1; tick();
        for (int i = 0; i < 64; i++) begin
            b = 8'($urandom);
            rxdat_i = b; rxval_i = 1'b1; pend.push_back(b);
            tick();
        end
        rxval_i = 1'b0;
        check("good_valid_pre", out_valid_o[1], 0);
        rxpktval_i = 1'b1; tick(); rxpktval_i = 1'b0;
        check("good_valid_commit", out_valid_o[1], 1);
        while (pend.size() > 0) oq.push_back(pend.pop_front());
        rxact_i = 1'b0; tick(); tick();
        check("good_drop", out_drop_cnt_o[15:8], exp_drop);
        out_ready_i = 2'b10;
        n = oq.size();
        for (int i = 0; i < n; i++) begin
            check("good_data", out_data_o[15:8], oq[0]);
            tick();
            b = oq.pop_front();
        end
        out_ready_i = '0;
        check("good_valid_drained", out_valid_o[1], 0);

        // OUT bad CRC: rollback
        rxact_i = 1'b1; tick();
        for (int i = 0; i < 64; i++) begin
            rxdat_i = 8'($urandom); rxval_i = 1'b1; tick();
        end
        rxval_i = 1'b0; rxact_i = 1'b0; tick(); tick();
        exp_drop = exp_drop + DROP_STEP;
        check("bad_valid", out_valid_o[1], 0);
        check("bad_drop", out_drop_cnt_o[15:8], exp_drop);
        check("bad_rxrdy", rxrdy_o, 1);

        // OUT good packet committed in the rxact fall cycle after a rollback
        rxact_i = 1'b1; tick();
        for (int i = 0; i < 10; i++) begin
            b = 8'($urandom);
            rxdat_i = b; rxval_i = 1'b1; pend.push_back(b);
            tick();
        end
        rxval_i = 1'b0; rxact_i = 1'b0; rxpktval_i = 1'b1; tick(); rxpktval_i = 1'b0;
        while (pend.size() > 0) oq.push_back(pend.pop_front());
        check("fall_commit_valid", out_valid_o[1], 1);
        tick();
        check("fall_commit_drop", out_drop_cnt_o[15:8], exp_drop);
        out_ready_i = 2'b10;
        n = oq.size();
        for (int i = 0; i < n; i++) begin
            check("fall_commit_data", out_data_o[15:8], oq[0]);
            tick();
            b = oq.pop_front();
        end
        out_ready_i = '0;
        check("fall_commit_drained", out_valid_o[1], 0);

        // Endpoint 0: rx bytes discarded
        endpt_i = 4'd0; rxact_i = 1'b1; tick();
        rxdat_i = 8'h3C; rxval_i = 1'b1; tick(); rxval_i = 1'b0;
        rxpktval_i = 1'b1; tick(); rxpktval_i = 1'b0; rxact_i = 1'b0; tick();
        check("ep0_discard", out_valid_o, 0);

        // Fill ch0 to full, then push+pop across the pointer wrap
        endpt_i = 4'd1;
        for (int i = 0; i < DEPTH; i++) begin
            if (i == DEPTH - 1) check("fill_ready_last", in_ready_o[0], 1);
            b = 8'($urandom);
            in_data_i[7:0] = b; in_valid_i = 2'b01; q0.push_back(b);
            tick();
        end
        in_valid_i = '0; tick();
        check("full_ready", in_ready_o[0], (q0.size() < DEPTH) ? 1'b1 : 1'b0);
        check("full_len", txdat_len_o, exp_len(q0.size()));
        in_data_i[7:0] = 8'hA5; in_valid_i = 2'b01; tick(); in_valid_i = '0;
        check("full_push_ignored", in_ready_o[0], 0);
        txact_i = 1'b1; tick(); tick();
        check("wrap_dat_first", txdat_o, q0[0]);
        txpop_i = 1'b1; tick(); txpop_i = 1'b0;
        b = q0.pop_front();
        check("wrap_ready_after_pop", in_ready_o[0], 1);
        txpop_i = 1'b1; in_valid_i = 2'b01;
        for (int i = 0; i < 1100; i++) begin
            b = 8'($urandom);
            in_data_i[7:0] = b;
            check("pushpop_dat", txdat_o, q0[0]);
            check("pushpop_ready", in_ready_o[0], (q0.size() < DEPTH) ? 1'b1 : 1'b0);
            check("pushpop_txval", txval_o, 1);
            tick();
            void'(q0.pop_front());
            q0.push_back(b);
        end
        in_valid_i = '0;
        n = q0.size();
        for (int i = 0; i < n; i++) begin
            check("drain_dat", txdat_o, q0[0]);
            tick();
            void'(q0.pop_front());
        end
        txpop_i = 1'b0; txact_i = 1'b0; tick();
        check("drain_cork", txcork_o, 1);

        // Reset mid-packet: everything emptied, nothing committed
        endpt_i = 4'd2; rxact_i = 1'b1; tick();
        for (int i = 0; i < 5; i++) begin
            rxdat_i = 8'($urandom); rxval_i = 1'b1;
            in_data_i[7:0] = 8'($urandom); in_valid_i = 2'b01;
            tick();
        end
        rstn_i = 1'b0; rxval_i = 1'b0; rxact_i = 1'b0; in_valid_i = '0; endpt_i = 4'd1; #1;
        check("midrst_out_valid", out_valid_o, 0);
        check("midrst_in_ready", in_ready_o, 2'b11);
        check("midrst_cork", txcork_o, 1);
        check("midrst_len", txdat_len_o, 0);
        check("midrst_drop", out_drop_cnt_o, 0);
        tick();
        rstn_i = 1'b1; tick(); tick();
        check("postrst_out_valid", out_valid_o, 0);
        check("postrst_cork", txcork_o, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
